lcd_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 81 ++++++++
 rtl/lcd_nibble_tx.sv | 94 +++++++++
 rtl/lcd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, default timing and init table for the HD44780 4-bit controller.
package lcd_pkg;

  localparam int unsigned CNT_W      = 20;
  localparam int unsigned TX_CNT_W   = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned INIT_STEPS = 4;
  localparam int unsigned INIT_IDX_W = 2;

  // Default timing at 27 MHz
  localparam logic [CNT_W-1:0]    T_PON_DEF   = 20'd405000;
  localparam logic [CNT_W-1:0]    T_INIT1_DEF = 20'd110700;
  localparam logic [CNT_W-1:0]    T_INIT2_DEF = 20'd2700;
  localparam logic [CNT_W-1:0]    T_EXEC_DEF  = 20'd1000;
  localparam logic [CNT_W-1:0]    T_CLR_DEF   = 20'd41040;
  localparam logic [TX_CNT_W-1:0] T_AS_DEF    = 8'd3;
  localparam logic [TX_CNT_W-1:0] T_PW_DEF    = 8'd13;
  localparam logic [TX_CNT_W-1:0] T_H_DEF     = 8'd13;

  // Init nibbles, step 0 in the low slot: 3, 3, 3, 2
  localparam logic [INIT_STEPS*NIB_W-1:0] INIT_NIB_TABLE = {4'h2, 4'h3, 4'h3, 4'h3};

  typedef enum logic [2:0] {
    ST_PON_WAIT,
    ST_INIT,
    ST_INIT_WAIT,
    ST_XFER_HI,
    ST_XFER_LO,
    ST_EXEC_WAIT,
    ST_IDLE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_E_HI,
    TX_E_LO
  } tx_state_t;

  typedef enum logic [1:0] {
    WAIT_INIT1,
    WAIT_INIT2,
    WAIT_EXEC
  } wait_sel_t;

  typedef struct packed {
    logic              rs;
    logic [BYTE_W-1:0] data;
  } lcd_byte_t;

  // Nibble sent at a given init step
  function automatic logic [NIB_W-1:0] init_nibble(input logic [INIT_IDX_W-1:0] idx);
    return INIT_NIB_TABLE[{idx, 2'b00} +: NIB_W];
  endfunction

  // Wait that follows a given init step
  function automatic wait_sel_t init_wait_sel(input logic [INIT_IDX_W-1:0] idx);
    case (idx)
      2'd0:    return WAIT_INIT1;
      2'd1:    return WAIT_INIT2;
      default: return WAIT_EXEC;
    endcase
  endfunction

  // Clear / return-home commands need the long execution wait
  function automatic logic is_slow_cmd(input lcd_byte_t b);
    return !b.rs && ((b.data == 8'h01) || (b.data == 8'h02) || (b.data == 8'h03));
  endfunction

  // Final counter value of a wait phase; a zero limit behaves as one cycle
  function automatic logic [CNT_W-1:0] wait_last(input logic [CNT_W-1:0] lim);
    return (lim == '0) ? '0 : lim - CNT_W'(1);
  endfunction

  // Final counter value of a nibble phase; a zero limit behaves as one cycle
  function automatic logic [TX_CNT_W-1:0] tx_last(input logic [TX_CNT_W-1:0] lim);
    return (lim == '0) ? '0 : lim - TX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD bus: setup, E high, E low hold, then done.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter logic [TX_CNT_W-1:0] T_AS = T_AS_DEF,
  parameter logic [TX_CNT_W-1:0] T_PW = T_PW_DEF,
  parameter logic [TX_CNT_W-1:0] T_H  = T_H_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rs,
  input  logic [NIB_W-1:0] nibble,
  output logic             done_c,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic [NIB_W-1:0] lcd_db
);

  localparam logic [TX_CNT_W-1:0] AS_LAST = tx_last(T_AS);
  localparam logic [TX_CNT_W-1:0] PW_LAST = tx_last(T_PW);
  localparam logic [TX_CNT_W-1:0] H_LAST  = tx_last(T_H);

  tx_state_t           state_q, state_d;
  logic [TX_CNT_W-1:0] cnt_q, cnt_d;
  logic                e_d, rs_d;
  logic [NIB_W-1:0]    db_d;

  // State, phase counter and bus registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_db  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcd_e   <= e_d;
      lcd_rs  <= rs_d;
      lcd_db  <= db_d;
    end
  end

  // Phase sequencing; a start on the final hold cycle chains straight into the next setup
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = lcd_e;
    rs_d    = lcd_rs;
    db_d    = lcd_db;
    done_c  = 1'b0;
    case (state_q)
      TX_IDLE: ;
      TX_SETUP: begin
        if (cnt_q == AS_LAST) begin
          state_d = TX_E_HI;
          cnt_d   = '0;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + TX_CNT_W'(1);
        end
      end
      TX_E_HI: begin
        if (cnt_q == PW_LAST) begin
          state_d = TX_E_LO;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + TX_CNT_W'(1);
        end
      end
      TX_E_LO: begin
        if (cnt_q == H_LAST) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
          done_c  = 1'b1;
        end else begin
          cnt_d = cnt_q + TX_CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (start) begin
      state_d = TX_SETUP;
      cnt_d   = '0;
      e_d     = 1'b0;
      rs_d    = rs;
      db_d    = nibble;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit controller: power-on init, byte split into nibbles, exec waits, busy/ovf.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter logic [CNT_W-1:0]    T_PON   = T_PON_DEF,
  parameter logic [CNT_W-1:0]    T_INIT1 = T_INIT1_DEF,
  parameter logic [CNT_W-1:0]    T_INIT2 = T_INIT2_DEF,
  parameter logic [CNT_W-1:0]    T_EXEC  = T_EXEC_DEF,
  parameter logic [CNT_W-1:0]    T_CLR   = T_CLR_DEF,
  parameter logic [TX_CNT_W-1:0] T_AS    = T_AS_DEF,
  parameter logic [TX_CNT_W-1:0] T_PW    = T_PW_DEF,
  parameter logic [TX_CNT_W-1:0] T_H     = T_H_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_rs,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  output logic              ovf,
  output logic              lcd_e,
  output logic              lcd_rw,
  output logic              lcd_rs,
  output logic [NIB_W-1:0]  lcd_db
);

  ctrl_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [INIT_IDX_W-1:0] idx_q, idx_d;
  lcd_byte_t             byte_q, byte_d;
  logic                  busy_d, ovf_d;

  logic [CNT_W-1:0]      wait_lim_c;
  logic                  cnt_end_c;
  logic                  tx_start_c;
  logic                  tx_rs_c;
  logic [NIB_W-1:0]      tx_nib_c;
  logic                  tx_done_c;

  // Writes only, never reads the LCD
  assign lcd_rw = 1'b0;

  lcd_nibble_tx #(
    .T_AS (T_AS),
    .T_PW (T_PW),
    .T_H  (T_H)
  ) u_tx (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .start   (tx_start_c),
    .rs      (tx_rs_c),
    .nibble  (tx_nib_c),
    .done_c  (tx_done_c),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_db  (lcd_db)
  );

  // Length of the wait phase currently being counted
  always_comb begin
    wait_lim_c = T_EXEC;
    case (state_q)
      ST_PON_WAIT: wait_lim_c = T_PON;
      ST_INIT_WAIT: begin
        case (init_wait_sel(idx_q))
          WAIT_INIT1: wait_lim_c = T_INIT1;
          WAIT_INIT2: wait_lim_c = T_INIT2;
          default:    wait_lim_c = T_EXEC;
        endcase
      end
      ST_EXEC_WAIT: wait_lim_c = is_slow_cmd(byte_q) ? T_CLR : T_EXEC;
      default: ;
    endcase
  end

  assign cnt_end_c = (cnt_q == wait_last(wait_lim_c));

  // Controller state and status registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PON_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      busy    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      busy    <= busy_d;
      ovf     <= ovf_d;
    end
  end

  // Sequencing of init steps, byte nibbles and execution waits
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    busy_d     = busy;
    ovf_d      = ovf;
    tx_start_c = 1'b0;
    tx_rs_c    = 1'b0;
    tx_nib_c   = init_nibble(idx_q);
    case (state_q)
      ST_PON_WAIT: begin
        if (cnt_end_c) begin
          state_d    = ST_INIT;
          cnt_d      = '0;
          tx_start_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (tx_done_c) begin
          state_d = ST_INIT_WAIT;
          cnt_d   = '0;
        end
      end
      ST_INIT_WAIT: begin
        if (cnt_end_c) begin
          cnt_d = '0;
          if (idx_q == INIT_IDX_W'(INIT_STEPS - 1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            idx_d      = idx_q + INIT_IDX_W'(1);
            state_d    = ST_INIT;
            tx_start_c = 1'b1;
            tx_nib_c   = init_nibble(idx_d);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_XFER_HI: begin
        if (tx_done_c) begin
          state_d    = ST_XFER_LO;
          tx_start_c = 1'b1;
          tx_rs_c    = byte_q.rs;
          tx_nib_c   = byte_q.data[NIB_W-1:0];
        end
      end
      ST_XFER_LO: begin
        if (tx_done_c) begin
          state_d = ST_EXEC_WAIT;
          cnt_d   = '0;
        end
      end
      ST_EXEC_WAIT: begin
        if (cnt_end_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (wr_en) begin
          byte_d.rs   = wr_rs;
          byte_d.data = wr_data;
          state_d     = ST_XFER_HI;
          busy_d      = 1'b1;
          tx_start_c  = 1'b1;
          tx_rs_c     = wr_rs;
          tx_nib_c    = wr_data[BYTE_W-1:NIB_W];
        end
      end
      default: begin
        state_d = ST_PON_WAIT;
        cnt_d   = '0;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
    if (wr_en && busy) ovf_d = 1'b1;
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl with the small timing set.
module tb_lcd_ctrl;

  localparam int T_PON   = 20;
  localparam int T_INIT1 = 10;
  localparam int T_INIT2 = 5;
  localparam int T_EXEC  = 4;
  localparam int T_CLR   = 12;
  localparam int T_AS    = 1;
  localparam int T_PW    = 2;
  localparam int T_H     = 2;
  localparam int NIB     = T_AS + T_PW + T_H;   // 5 cycles per nibble
  localparam int BUSY_FAST = 2 * NIB + T_EXEC;  // 14
  localparam int BUSY_SLOW = 2 * NIB + T_CLR;   // 22
  localparam int INIT_BUSY = T_PON + 4 * NIB + T_INIT1 + T_INIT2 + 2 * T_EXEC; // 63

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic       wr_rs   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, ovf, lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_db;

  lcd_ctrl #(
    .T_PON   (20'd20),
    .T_INIT1 (20'd10),
    .T_INIT2 (20'd5),
    .T_EXEC  (20'd4),
    .T_CLR   (20'd12),
    .T_AS    (8'd1),
    .T_PW    (8'd2),
    .T_H     (8'd2)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_rs   (wr_rs),
    .wr_data (wr_data),
    .busy    (busy),
    .ovf     (ovf),
    .lcd_e   (lcd_e),
    .lcd_rw  (lcd_rw),
    .lcd_rs  (lcd_rs),
    .lcd_db  (lcd_db)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [3:0] db;
    int         gap;
    bit         from_ref;
  } pulse_t;

  pulse_t exp_q[$];
  int     ref_cyc   = 0;
  int     last_rise = 0;
  int     n_cmp     = 0;
  int     n_bad     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic rs, input logic [3:0] db, input int gap, input bit from_ref);
    pulse_t p;
    p.rs = rs;
    p.db = db;
    p.gap = gap;
    p.from_ref = from_ref;
    exp_q.push_back(p);
  endtask

  // Monitor: every E rise pops the next expected nibble; E fall checks bus stability
  initial begin : monitor
    logic       prev_e;
    logic       hold_rs;
    logic [3:0] hold_db;
    pulse_t     p;
    int         g;
    prev_e  = 1'b0;
    hold_rs = 1'b0;
    hold_db = 4'h0;
    forever begin
      @(negedge sys_clk);
      if (lcd_e && !prev_e) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL e_pulse: got rs=%0d db=%h expected no pulse (cycle %0d)", lcd_rs, lcd_db, cyc);
        end else begin
          p = exp_q.pop_front();
          g = p.from_ref ? (cyc - ref_cyc) : (cyc - last_rise);
          check("e_rs", int'(lcd_rs), int'(p.rs));
          check("e_db", int'(lcd_db), int'(p.db));
          check("e_gap", g, p.gap);
          check("e_rw", int'(lcd_rw), 0);
        end
        last_rise = cyc;
        hold_rs   = lcd_rs;
        hold_db   = lcd_db;
      end
      if (!lcd_e && prev_e && rst_n) begin
        check("bus_stable", int'({lcd_rs, lcd_db}), int'({hold_rs, hold_db}));
      end
      prev_e = lcd_e;
    end
  end

  // Count negedges with busy high, optionally injecting one write at iteration inject_at
  task automatic measure_busy(input int inject_at, output int n);
    n = 0;
    while (busy && n < 1000) begin
      if (n == inject_at) begin
        wr_en   = 1'b1;
        wr_rs   = 1'b0;
        wr_data = 8'h01;
      end else begin
        wr_en = 1'b0;
      end
      n++;
      @(negedge sys_clk);
    end
    wr_en = 1'b0;
  endtask

  // Issue one byte at a negedge where busy is low and check its busy duration
  task automatic send(input string name, input logic rs, input logic [7:0] d,
                      input int busy_exp, input int inject_at);
    int n;
    check({name, "_idle"}, int'(busy), 0);
    wr_en   = 1'b1;
    wr_rs   = rs;
    wr_data = d;
    ref_cyc = cyc;
    expect_pulse(rs, d[7:4], T_AS + 1, 1'b1);
    expect_pulse(rs, d[3:0], NIB, 1'b0);
    @(negedge sys_clk);
    wr_en = 1'b0;
    check({name, "_busy_rise"}, int'(busy), 1);
    measure_busy(inject_at, n);
    check({name, "_busy_len"}, n, busy_exp);
  endtask

  task automatic expect_init();
    expect_pulse(1'b0, 4'h3, T_PON + T_AS, 1'b1);
    expect_pulse(1'b0, 4'h3, NIB + T_INIT1, 1'b0);
    expect_pulse(1'b0, 4'h3, NIB + T_INIT2, 1'b0);
    expect_pulse(1'b0, 4'h2, NIB + T_EXEC, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int k;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_busy", int'(busy), 1);
    check("rst_ovf", int'(ovf), 0);
    check("rst_e", int'(lcd_e), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_db", int'(lcd_db), 0);
    check("rst_rw", int'(lcd_rw), 0);

    // Power-on init
    rst_n   = 1'b1;
    ref_cyc = cyc;
    expect_init();
    measure_busy(-1, n);
    check("init_busy_len", n, INIT_BUSY);
    check("init_ovf", int'(ovf), 0);
    check("init_hold_db", int'(lcd_db), 2);

    // Normal data byte, issued on the first idle cycle
    send("d48", 1'b1, 8'h48, BUSY_FAST, -1);
    check("hold_db_48", int'(lcd_db), 8);
    check("hold_rs_48", int'(lcd_rs), 1);

    // Execution wait selection
    send("c01", 1'b0, 8'h01, BUSY_SLOW, -1);
    send("d01", 1'b1, 8'h01, BUSY_FAST, -1);
    send("c02", 1'b0, 8'h02, BUSY_SLOW, -1);
    send("c03", 1'b0, 8'h03, BUSY_SLOW, -1);
    send("c04", 1'b0, 8'h04, BUSY_FAST, -1);

    // Bus holds in idle
    repeat (3) @(negedge sys_clk);
    check("idle_db", int'(lcd_db), 4);
    check("idle_rs", int'(lcd_rs), 0);
    check("idle_e", int'(lcd_e), 0);
    check("idle_ovf", int'(ovf), 0);

    // Write while busy is dropped and flagged
    send("d5a", 1'b1, 8'h5A, BUSY_FAST, 3);
    check("ovf_set", int'(ovf), 1);
    repeat (4) @(negedge sys_clk);
    send("d33", 1'b1, 8'h33, BUSY_FAST, -1);
    check("ovf_sticky", int'(ovf), 1);

    // Reset during E high aborts and restarts init
    repeat (2) @(negedge sys_clk);
    wr_en   = 1'b1;
    wr_rs   = 1'b1;
    wr_data = 8'hC3;
    ref_cyc = cyc;
    expect_pulse(1'b1, 4'hC, T_AS + 1, 1'b1);
    @(negedge sys_clk);
    wr_en = 1'b0;
    k = 0;
    while (!lcd_e && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    check("e_hi_reached", int'(lcd_e), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_e", int'(lcd_e), 0);
    check("abort_busy", int'(busy), 1);
    check("abort_ovf", int'(ovf), 0);
    check("abort_db", int'(lcd_db), 0);
    exp_q.delete();
    @(negedge sys_clk);
    rst_n   = 1'b1;
    ref_cyc = cyc;
    expect_init();
    measure_busy(30, n);
    check("reinit_busy_len", n, INIT_BUSY);
    check("reinit_ovf", int'(ovf), 1);

    // Writes still work after the restart
    send("d7e", 1'b1, 8'h7E, BUSY_FAST, -1);

    repeat (5) @(negedge sys_clk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
